viterbi_burst_channel: RTL and testbench

//  Parametrised noisy channel between convolutional encoder and Viterbi decoder.

---
 rtl/viterbi_burst_channel.sv | 181 ++++++++++++++++++
 tb/tb_viterbi_burst_channel.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/viterbi_burst_channel.sv
// Noisy channel model: registers encoder symbols and flips FLIP_MASK bits in periodic or LFSR-triggered bursts.
// Optional error statistics counters are built when VITERBI_CHAN_STATS_EN is defined.
module viterbi_burst_channel #(
  parameter int          W            = 2,
  parameter int          PERIOD_LOG2  = 4,
  parameter int          BURST_OFFSET = 1,
  parameter int          BURST_LEN    = 2,
  parameter logic [W-1:0] FLIP_MASK   = {W{1'b1}},
  parameter int          MODE         = 0,
  parameter int          THRESH       = 16,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             valid_i,
  input  logic [W-1:0]     sym_i,
  output logic             valid_o,
  output logic [W-1:0]     sym_o,
  output logic [W-1:0]     clean_o,
  output logic             err_o,
  output logic [CNT_W-1:0] sym_ct_o,
  output logic [CNT_W-1:0] bit_err_ct_o
);

  localparam int PH_W = (PERIOD_LOG2 < 1) ? 1 : PERIOD_LOG2;
  localparam int BC_W = $clog2(BURST_LEN + 1);
  localparam logic [PH_W-1:0] OFFS    = PH_W'(BURST_OFFSET);
  localparam logic [BC_W-1:0] BLEN_M1 = BC_W'(BURST_LEN - 1);

  if ((BURST_OFFSET + BURST_LEN) > (1 << PERIOD_LOG2)) begin : g_err_straddle
    $error("viterbi_burst_channel: BURST_OFFSET+BURST_LEN exceeds the period");
  end
  if (LFSR_SEED == 16'h0000) begin : g_err_seed
    $error("viterbi_burst_channel: LFSR_SEED must be nonzero");
  end
  if (THRESH > 256) begin : g_err_thresh
    $error("viterbi_burst_channel: THRESH must be 0..256");
  end

  typedef enum logic {GAP = 1'b0, BURST = 1'b1} state_t;

  state_t          r_state, w_state_nx;
  logic [BC_W-1:0] r_bcnt, w_bcnt_nx;
  logic [PH_W-1:0] r_phase;
  logic [15:0]     r_lfsr;
  logic            w_lfsr_fb;
  logic            w_trig;
  logic            w_hit;

  logic            r_valid;
  logic [W-1:0]    r_sym;
  logic [W-1:0]    r_clean;
  logic            r_err;

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Trigger looks at the LFSR value before this symbol's shift.
  always_comb begin
    w_trig = 1'b0;
    if (MODE == 0) begin
      w_trig = (r_phase == OFFS);
    end else begin
      w_trig = ({1'b0, r_lfsr[7:0]} < 9'(THRESH));
    end
  end

  // A single-symbol burst is fully served by its trigger, so the FSM never leaves GAP.
  always_comb begin
    w_state_nx = r_state;
    w_bcnt_nx  = r_bcnt;
    w_hit      = 1'b0;
    if (valid_i) begin
      unique case (r_state)
        GAP: begin
          if (w_trig) begin
            w_hit = enable_i;
            if (BURST_LEN > 1) begin
              w_state_nx = BURST;
              w_bcnt_nx  = BC_W'(1);
            end
          end
        end
        BURST: begin
          w_hit = enable_i;
          if (r_bcnt == BLEN_M1) begin
            w_state_nx = GAP;
            w_bcnt_nx  = '0;
          end else begin
            w_bcnt_nx  = r_bcnt + 1'b1;
          end
        end
        default: begin
          w_state_nx = GAP;
          w_bcnt_nx  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= GAP;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_bcnt  <= w_bcnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= '0;
      r_lfsr  <= LFSR_SEED;
    end else if (valid_i) begin
      r_phase <= (PERIOD_LOG2 == 0) ? '0 : r_phase + 1'b1;
      r_lfsr  <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  // Output stage: one register between encoder and decoder.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_sym   <= '0;
      r_clean <= '0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_sym   <= sym_i ^ (w_hit ? FLIP_MASK : {W{1'b0}});
        r_clean <= sym_i;
        r_err   <= w_hit;
      end
    end
  end

  assign valid_o = r_valid;
  assign sym_o   = r_sym;
  assign clean_o = r_clean;
  assign err_o   = r_err;

`ifdef VITERBI_CHAN_STATS_EN
  localparam int SW = CNT_W + 33;

  function automatic logic [31:0] popcnt(input logic [W-1:0] m);
    popcnt = '0;
    for (int i = 0; i < W; i++) popcnt = popcnt + 32'(m[i]);
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [31:0] inc);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(inc);
    if (s > SW'({CNT_W{1'b1}})) sat_add = {CNT_W{1'b1}};
    else                        sat_add = s[CNT_W-1:0];
  endfunction

  localparam logic [31:0] POP = popcnt(FLIP_MASK);

  logic [CNT_W-1:0] r_sym_ct;
  logic [CNT_W-1:0] r_bit_ct;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sym_ct <= '0;
      r_bit_ct <= '0;
    end else if (valid_i) begin
      r_sym_ct <= sat_add(r_sym_ct, 32'd1);
      if (w_hit) r_bit_ct <= sat_add(r_bit_ct, POP);
    end
  end

  assign sym_ct_o     = r_sym_ct;
  assign bit_err_ct_o = r_bit_ct;
`else
  assign sym_ct_o     = '0;
  assign bit_err_ct_o = '0;
`endif

endmodule

// File: tb/tb_viterbi_burst_channel.sv
// Directed bench for viterbi_burst_channel: periodic, random-mode extremes, saturation and reset abort.
module tb_viterbi_burst_channel;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       vld = 1'b0;
  logic [1:0] sym = 2'b00;

  logic        p_vo, p_eo;
  logic [1:0]  p_so, p_co;
  logic [15:0] p_sct, p_bct;
  logic        a_vo, a_eo;
  logic [1:0]  a_so, a_co;
  logic [15:0] a_sct, a_bct;
  logic        b_vo, b_eo;
  logic [1:0]  b_so, b_co;
  logic [3:0]  b_sct, b_bct;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  viterbi_burst_channel u_per (
    .clk(clk), .rst(rst), .enable_i(en), .valid_i(vld), .sym_i(sym),
    .valid_o(p_vo), .sym_o(p_so), .clean_o(p_co), .err_o(p_eo),
    .sym_ct_o(p_sct), .bit_err_ct_o(p_bct)
  );

  viterbi_burst_channel #(.MODE(1), .THRESH(0)) u_r0 (
    .clk(clk), .rst(rst), .enable_i(en), .valid_i(vld), .sym_i(sym),
    .valid_o(a_vo), .sym_o(a_so), .clean_o(a_co), .err_o(a_eo),
    .sym_ct_o(a_sct), .bit_err_ct_o(a_bct)
  );

  viterbi_burst_channel #(.MODE(1), .THRESH(256), .BURST_LEN(3), .CNT_W(4)) u_r256 (
    .clk(clk), .rst(rst), .enable_i(en), .valid_i(vld), .sym_i(sym),
    .valid_o(b_vo), .sym_o(b_so), .clean_o(b_co), .err_o(b_eo),
    .sym_ct_o(b_sct), .bit_err_ct_o(b_bct)
  );

  typedef struct {
    logic       en;
    logic       vld;
    logic [1:0] sym;
    logic       evld;
    logic [1:0] esym;
    logic [1:0] eclean;
    logic       eerr;
    int         sct;
    int         bct;
  } vec_t;

  vec_t tbl[56];

  function automatic logic [31:0] st(input int v);
`ifdef VITERBI_CHAN_STATS_EN
    return 32'(v);
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic v, input logic [1:0] s);
    en  = e;
    vld = v;
    sym = s;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int a_errs, b_errs, p_errs;
    logic pe;

    for (int i = 0; i < 16; i++) begin
      pe = (i == 1) || (i == 2);
      tbl[i] = '{1'b1, 1'b1, 2'b00, 1'b1, pe ? 2'b11 : 2'b00, 2'b00, pe,
                 i + 1, (i == 0) ? 0 : ((i == 1) ? 2 : 4)};
    end
    for (int i = 0; i < 32; i++)
      tbl[16 + i] = '{1'b0, 1'b1, 2'b01, 1'b1, 2'b01, 2'b01, 1'b0, 17 + i, 4};
    tbl[48] = '{1'b1, 1'b1, 2'b10, 1'b1, 2'b10, 2'b10, 1'b0, 49, 4};
    tbl[49] = '{1'b1, 1'b0, 2'b00, 1'b0, 2'b10, 2'b10, 1'b0, 49, 4};
    tbl[50] = '{1'b1, 1'b1, 2'b10, 1'b1, 2'b01, 2'b10, 1'b1, 50, 6};
    tbl[51] = '{1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 2'b10, 1'b1, 50, 6};
    tbl[52] = '{1'b1, 1'b1, 2'b01, 1'b1, 2'b10, 2'b01, 1'b1, 51, 8};
    tbl[53] = '{1'b1, 1'b0, 2'b00, 1'b0, 2'b10, 2'b01, 1'b1, 51, 8};
    tbl[54] = '{1'b1, 1'b1, 2'b11, 1'b1, 2'b11, 2'b11, 1'b0, 52, 8};
    tbl[55] = '{1'b1, 1'b0, 2'b00, 1'b0, 2'b11, 2'b11, 1'b0, 52, 8};

    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(p_vo), 0);
    chk("rst_sym",   32'(p_so), 0);
    chk("rst_clean", 32'(p_co), 0);
    chk("rst_err",   32'(p_eo), 0);
    chk("rst_symct", 32'(p_sct), 0);
    chk("rst_bitct", 32'(p_bct), 0);
    chk("rst_r256_sym", 32'(b_so), 0);
    rst = 1'b1;

    for (int i = 0; i < 56; i++) begin
      step(tbl[i].en, tbl[i].vld, tbl[i].sym);
      chk($sformatf("v%0d_valid", i), 32'(p_vo),  32'(tbl[i].evld));
      chk($sformatf("v%0d_sym", i),   32'(p_so),  32'(tbl[i].esym));
      chk($sformatf("v%0d_clean", i), 32'(p_co),  32'(tbl[i].eclean));
      chk($sformatf("v%0d_err", i),   32'(p_eo),  32'(tbl[i].eerr));
      chk($sformatf("v%0d_symct", i), 32'(p_sct), st(tbl[i].sct));
      chk($sformatf("v%0d_bitct", i), 32'(p_bct), st(tbl[i].bct));
    end

    // 1000 symbols: THRESH=0 never fires, THRESH=256 always fires, periodic repeats every 16.
    pulse_rst();
    a_errs = 0;
    b_errs = 0;
    p_errs = 0;
    for (int k = 0; k < 1000; k++) begin
      step(1'b1, 1'b1, 2'b00);
      pe = ((k % 16) == 1) || ((k % 16) == 2);
      if (a_eo !== 1'b0 || a_so !== 2'b00) a_errs++;
      if (b_eo !== 1'b1 || b_so !== 2'b11) b_errs++;
      if (p_eo !== pe || p_so !== (pe ? 2'b11 : 2'b00)) p_errs++;
      if (k == 6)  chk("r256_bitct_7sym",  32'(b_bct), st(14));
      if (k == 7)  chk("r256_bitct_8sym",  32'(b_bct), st(15));
      if (k == 13) chk("r256_symct_14sym", 32'(b_sct), st(14));
      if (k == 14) chk("r256_symct_15sym", 32'(b_sct), st(15));
    end
    chk("r0_no_err",      32'(a_errs), 0);
    chk("r256_all_hit",   32'(b_errs), 0);
    chk("per_1000_pattern", 32'(p_errs), 0);
    chk("r0_symct",   32'(a_sct), st(1000));
    chk("r0_bitct",   32'(a_bct), st(0));
    chk("r256_symct_sat", 32'(b_sct), st(15));
    chk("r256_bitct_sat", 32'(b_bct), st(15));
    chk("per_symct_1000", 32'(p_sct), st(1000));
    chk("per_bitct_1000", 32'(p_bct), st(252));

    // Reset asserted mid-burst clears outputs immediately and aborts the burst.
    pulse_rst();
    step(1'b1, 1'b1, 2'b00);
    chk("ab_s0_err", 32'(p_eo), 0);
    step(1'b1, 1'b1, 2'b00);
    chk("ab_s1_err", 32'(p_eo), 1);
    chk("ab_s1_sym", 32'(p_so), 32'h3);
    rst = 1'b0;
    #1;
    chk("ab_async_sym",   32'(p_so), 0);
    chk("ab_async_err",   32'(p_eo), 0);
    chk("ab_async_valid", 32'(p_vo), 0);
    chk("ab_async_symct", 32'(p_sct), 0);
    #1 rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step(1'b1, 1'b1, 2'b10);
      pe = (j == 1) || (j == 2);
      chk($sformatf("ab_post%0d_err", j), 32'(p_eo), 32'(pe));
      chk($sformatf("ab_post%0d_sym", j), 32'(p_so), pe ? 32'h1 : 32'h2);
    end

    // enable_i dropped mid-burst: flip suppressed, burst length still consumed.
    pulse_rst();
    step(1'b1, 1'b1, 2'b00);
    step(1'b1, 1'b1, 2'b00);
    chk("en_s1_err", 32'(p_eo), 1);
    step(1'b0, 1'b1, 2'b00);
    chk("en_s2_err", 32'(p_eo), 0);
    chk("en_s2_sym", 32'(p_so), 0);
    step(1'b1, 1'b1, 2'b00);
    chk("en_s3_err", 32'(p_eo), 0);
    chk("en_bitct",  32'(p_bct), st(2));
    chk("en_symct",  32'(p_sct), st(4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
